// File: rtl/assert_fail_collector_if.sv
// Bus bundle for assert_fail_collector: failure pulses, clear handshake, counter read port
// and first-failure status.
interface assert_fail_collector_if #(
  parameter int unsigned N_SRC = 8,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned TOT_W = 16,
  parameter int unsigned TS_W  = 16
);
  localparam int unsigned IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [N_SRC-1:0] fail_vec;
  logic             clr_req;
  logic             clr_ack;
  logic             rd_req;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_ack;
  logic [CNT_W-1:0] rd_cnt;
  logic             any_fail;
  logic             irq;
  logic [IDX_W-1:0] first_idx;
  logic [TS_W-1:0]  first_ts;
  logic [TOT_W-1:0] total_cnt;

  modport master (
    output fail_vec, clr_req, rd_req, rd_idx,
    input  clr_ack, rd_ack, rd_cnt, any_fail, irq, first_idx, first_ts, total_cnt
  );

  modport slave (
    input  fail_vec, clr_req, rd_req, rd_idx,
    output clr_ack, rd_ack, rd_cnt, any_fail, irq, first_idx, first_ts, total_cnt
  );
endinterface

// File: rtl/assert_fail_collector.sv
// Collects checker failure pulses into per-source and total saturating counters and latches the
// first failure. Define ASSERT_FAIL_TIMESTAMP_EN to build the first-failure cycle timestamp.
module assert_fail_collector #(
  parameter int unsigned N_SRC = 8,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned TOT_W = 16,
  parameter int unsigned TS_W  = 16
) (
  input logic                    clk,
  input logic                    rst,
  assert_fail_collector_if.slave bus
);
  localparam int unsigned IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int unsigned PC_W  = $clog2(N_SRC + 1);
  localparam int unsigned SUM_W = TOT_W + PC_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [TOT_W-1:0] TOT_MAX = '1;

  typedef enum logic [1:0] {IDLE, LATCHED, CLEARING} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt [N_SRC];
  logic [TOT_W-1:0] total_q;
  logic [TOT_W-1:0] total_nxt;
  logic [SUM_W-1:0] total_sum;
  logic [PC_W-1:0]  pop;
  logic [IDX_W-1:0] low_idx;
  logic             count_en;
  logic             capture;
  logic             clr_zero;
  logic [TS_W-1:0]  ts_now;
  logic             irq_q, clr_ack_q, any_fail_q, rd_ack_q;
  logic [CNT_W-1:0] rd_cnt_q;
  logic [IDX_W-1:0] first_idx_q;
  logic [TS_W-1:0]  first_ts_q;

  // Next-state: clear has priority over any failure in the same cycle
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.clr_req)        state_nxt = CLEARING;
        else if (|bus.fail_vec) state_nxt = LATCHED;
      end
      LATCHED:  if (bus.clr_req) state_nxt = CLEARING;
      CLEARING: state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  assign clr_zero = (state_nxt == CLEARING);
  assign count_en = (state != CLEARING) && !bus.clr_req;
  assign capture  = (state == IDLE) && !bus.clr_req && (|bus.fail_vec);

  // Popcount and lowest set index of the incoming failure vector
  always_comb begin
    pop     = '0;
    low_idx = '0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      pop = pop + PC_W'(bus.fail_vec[i]);
    end
    for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
      if (bus.fail_vec[i]) low_idx = IDX_W'(i);
    end
  end

  always_comb begin
    total_sum = SUM_W'(total_q) + SUM_W'(pop);
    total_nxt = (total_sum > SUM_W'(TOT_MAX)) ? TOT_MAX : total_sum[TOT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(N_SRC); i++) cnt[i] <= '0;
      total_q <= '0;
    end else if (clr_zero) begin
      for (int i = 0; i < int'(N_SRC); i++) cnt[i] <= '0;
      total_q <= '0;
    end else if (count_en) begin
      for (int i = 0; i < int'(N_SRC); i++) begin
        if (bus.fail_vec[i] && (cnt[i] != CNT_MAX)) cnt[i] <= cnt[i] + CNT_W'(1);
      end
      total_q <= total_nxt;
    end
  end

`ifdef ASSERT_FAIL_TIMESTAMP_EN
  logic [TS_W-1:0] ts;

  // Free-running cycle count, held at zero across the clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                           ts <= '0;
    else if ((state_nxt == CLEARING) || (state == CLEARING)) ts <= '0;
    else                                               ts <= ts + TS_W'(1);
  end

  assign ts_now = ts;
`else
  assign ts_now = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_q       <= 1'b0;
      clr_ack_q   <= 1'b0;
      any_fail_q  <= 1'b0;
      first_idx_q <= '0;
      first_ts_q  <= '0;
    end else begin
      irq_q      <= capture;
      clr_ack_q  <= (state_nxt == CLEARING);
      any_fail_q <= (state_nxt == LATCHED);
      if (clr_zero) begin
        first_idx_q <= '0;
        first_ts_q  <= '0;
      end else if (capture) begin
        first_idx_q <= low_idx;
        first_ts_q  <= ts_now;
      end
    end
  end

  // Read returns the counter as registered in the request cycle (pre-increment)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ack_q <= 1'b0;
      rd_cnt_q <= '0;
    end else begin
      rd_ack_q <= bus.rd_req;
      if (bus.rd_req && (32'(bus.rd_idx) < N_SRC)) rd_cnt_q <= cnt[bus.rd_idx];
      else                                         rd_cnt_q <= '0;
    end
  end

  assign bus.irq       = irq_q;
  assign bus.clr_ack   = clr_ack_q;
  assign bus.any_fail  = any_fail_q;
  assign bus.first_idx = first_idx_q;
  assign bus.first_ts  = first_ts_q;
  assign bus.total_cnt = total_q;
  assign bus.rd_ack    = rd_ack_q;
  assign bus.rd_cnt    = rd_cnt_q;
endmodule

// File: tb/tb_assert_fail_collector.sv
// Self-checking bench for assert_fail_collector: cycle model of the collector rules plus
// directed vectors with hand-computed expectations.
module tb_assert_fail_collector;
  localparam int N_SRC   = 8;
  localparam int CNT_W   = 8;
  localparam int TOT_W   = 16;
  localparam int TS_W    = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int TOT_MAX = (1 << TOT_W) - 1;
  localparam int TS_MOD  = 1 << TS_W;
`ifdef ASSERT_FAIL_TIMESTAMP_EN
  localparam bit TS_ON = 1'b1;
`else
  localparam bit TS_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  assert_fail_collector_if #(.N_SRC(N_SRC), .CNT_W(CNT_W), .TOT_W(TOT_W), .TS_W(TS_W)) bus ();

  assert_fail_collector #(.N_SRC(N_SRC), .CNT_W(CNT_W), .TOT_W(TOT_W), .TS_W(TS_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Behavioural model: what each output must show during the current cycle
  int m_cnt [N_SRC];
  int m_total, m_first_idx, m_first_ts, m_ts, m_rd_cnt;
  bit m_latched, m_clearing, m_irq, m_rd_ack;
  int pop, low;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_total = 0; m_first_idx = 0; m_first_ts = 0; m_ts = 0; m_rd_cnt = 0;
      m_latched = 0; m_clearing = 0; m_irq = 0; m_rd_ack = 0;
    end else begin
      m_rd_ack = bus.rd_req;
      m_rd_cnt = bus.rd_req ? m_cnt[bus.rd_idx] : 0;
      m_irq    = 0;
      if (m_clearing) begin
        m_clearing = 0;
        m_ts       = 0;
      end else if (bus.clr_req) begin
        m_clearing = 1; m_latched = 0; m_total = 0;
        m_first_idx = 0; m_first_ts = 0; m_ts = 0;
        foreach (m_cnt[i]) m_cnt[i] = 0;
      end else begin
        pop = 0; low = -1;
        for (int i = 0; i < N_SRC; i++) begin
          if (bus.fail_vec[i]) begin
            pop++;
            if (low < 0) low = i;
            if (m_cnt[i] < CNT_MAX) m_cnt[i]++;
          end
        end
        m_total = (m_total + pop > TOT_MAX) ? TOT_MAX : m_total + pop;
        if (!m_latched && low >= 0) begin
          m_latched = 1; m_first_idx = low; m_first_ts = m_ts; m_irq = 1;
        end
        m_ts = (m_ts + 1) % TS_MOD;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk("any_fail",  32'(bus.any_fail),  32'(m_latched));
    chk("irq",       32'(bus.irq),       32'(m_irq));
    chk("clr_ack",   32'(bus.clr_ack),   32'(m_clearing));
    chk("first_idx", 32'(bus.first_idx), m_first_idx);
    chk("first_ts",  32'(bus.first_ts),  TS_ON ? m_first_ts : 0);
    chk("total_cnt", 32'(bus.total_cnt), m_total);
    chk("rd_ack",    32'(bus.rd_ack),    32'(m_rd_ack));
    chk("rd_cnt",    32'(bus.rd_cnt),    m_rd_cnt);
  end

  task automatic drive(input logic [7:0] fv, input logic clr, input logic rd, input logic [2:0] idx);
    bus.fail_vec = fv;
    bus.clr_req  = clr;
    bus.rd_req   = rd;
    bus.rd_idx   = idx;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_total"},   32'(bus.total_cnt), 0);
    chk({nm, "_anyfail"}, 32'(bus.any_fail),  0);
    chk({nm, "_fidx"},    32'(bus.first_idx), 0);
    chk({nm, "_fts"},     32'(bus.first_ts),  0);
    chk({nm, "_irq"},     32'(bus.irq),       0);
    chk({nm, "_clrack"},  32'(bus.clr_ack),   0);
    chk({nm, "_rdack"},   32'(bus.rd_ack),    0);
    chk({nm, "_rdcnt"},   32'(bus.rd_cnt),    0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.fail_vec = '0; bus.clr_req = 1'b0; bus.rd_req = 1'b0; bus.rd_idx = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;

    // Five quiet cycles, then sources 2 and 4 fail together
    repeat (5) drive(8'h00, 0, 0, 0);
    drive(8'h14, 0, 0, 0);
    chk("first_irq", 32'(bus.irq), 1);
    chk("first_idx_2", 32'(bus.first_idx), 2);
    chk("first_total_2", 32'(bus.total_cnt), 2);
    chk("first_ts_5", 32'(bus.first_ts), TS_ON ? 5 : 0);
    drive(8'h00, 0, 1, 2);
    chk("irq_single", 32'(bus.irq), 0);
    chk("rd2_ack", 32'(bus.rd_ack), 1);
    chk("rd2_cnt", 32'(bus.rd_cnt), 1);
    drive(8'h00, 0, 1, 4);
    chk("rd4_cnt", 32'(bus.rd_cnt), 1);
    drive(8'h00, 0, 0, 0);
    chk("rd_idle_cnt", 32'(bus.rd_cnt), 0);

    // Clear, with a read issued in the clearing cycle
    drive(8'h00, 1, 0, 0);
    chk("clr_ack_hi", 32'(bus.clr_ack), 1);
    chk("clr_total", 32'(bus.total_cnt), 0);
    drive(8'h00, 1, 1, 2);
    chk("clr_ack_lo", 32'(bus.clr_ack), 0);
    chk("rd_in_clr", 32'(bus.rd_cnt), 0);
    drive(8'h00, 0, 0, 0);

    // Source 0 held for 300 cycles: per-source saturates, total does not
    repeat (300) drive(8'h01, 0, 0, 0);
    drive(8'h00, 0, 1, 0);
    chk("sat_rd0", 32'(bus.rd_cnt), 255);
    chk("sat_total300", 32'(bus.total_cnt), 300);

    // Clear request coinciding with a failure: failure discarded, no irq
    drive(8'h00, 1, 0, 0);
    drive(8'h00, 1, 0, 0);
    drive(8'h00, 0, 0, 0);
    drive(8'h01, 1, 0, 0);
    chk("clrwin_ack", 32'(bus.clr_ack), 1);
    drive(8'h01, 1, 0, 0);
    chk("clrwin_total", 32'(bus.total_cnt), 0);
    chk("clrwin_any", 32'(bus.any_fail), 0);
    drive(8'h00, 0, 0, 0);
    chk("clrwin_irq", 32'(bus.irq), 0);

    // Read racing an increment of the same source
    repeat (4) drive(8'h08, 0, 0, 0);
    drive(8'h08, 0, 1, 3);
    chk("race_rd3_pre", 32'(bus.rd_cnt), 4);
    drive(8'h00, 0, 1, 3);
    chk("race_rd3_post", 32'(bus.rd_cnt), 5);

    // Total saturation with all sources failing every cycle
    drive(8'h00, 1, 0, 0);
    drive(8'h00, 1, 0, 0);
    repeat (8200) drive(8'hFF, 0, 0, 0);
    drive(8'h00, 0, 1, 7);
    chk("tot_sat", 32'(bus.total_cnt), 65535);
    chk("tot_sat_rd7", 32'(bus.rd_cnt), 255);

    // Asynchronous reset mid-LATCHED and mid-read
    drive(8'h00, 1, 0, 0);
    drive(8'h00, 1, 0, 0);
    drive(8'h07, 0, 0, 0);
    drive(8'h0F, 0, 0, 0);
    chk("pre_rst_total7", 32'(bus.total_cnt), 7);
    bus.fail_vec = 8'h00; bus.rd_req = 1'b1; bus.rd_idx = 3'd3;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_abort_rdack", 32'(bus.rd_ack), 0);

    // Failure in the first cycle after reset release is captured
    drive(8'h40, 0, 0, 0);
    chk("post_rst_irq", 32'(bus.irq), 1);
    chk("post_rst_idx6", 32'(bus.first_idx), 6);
    chk("post_rst_ts0", 32'(bus.first_ts), 0);
    chk("post_rst_total1", 32'(bus.total_cnt), 1);
    drive(8'h00, 0, 0, 0);
    @(negedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/assert_fail_collector.md
ASSERT_FAIL_COLLECTOR -- requirements
Module: assert_fail_collector

Interface
- REQ-001 SHALL have parameter N_SRC, default 8: number of checker failure sources (1..32).
- REQ-002 SHALL have parameter CNT_W, default 8: width of each per-source saturating failure counter.
- REQ-003 SHALL have parameter TOT_W, default 16: width of the total failure counter.
- REQ-004 SHALL have parameter TS_W, default 16: width of the cycle timestamp.
- REQ-005 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
- REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
- REQ-007 SHALL have port fail_vec, input, N_SRC bits: one-cycle failure pulses, one bit per checker instance.
- REQ-008 SHALL have port clr_req, input, 1 bit: clear request, held until clr_ack.
- REQ-009 SHALL have port clr_ack, output, 1 bit: one-cycle clear acknowledge.
- REQ-010 SHALL have port rd_req, input, 1 bit: counter read strobe.
- REQ-011 SHALL have port rd_idx, input, $clog2(N_SRC) bits (minimum 1): index of the source to read.
- REQ-012 SHALL have port rd_ack, output, 1 bit: read data valid, one cycle.
- REQ-013 SHALL have port rd_cnt, output, CNT_W bits: counter value of the selected source.
- REQ-014 SHALL have port any_fail, output, 1 bit: sticky flag, high once any failure has occurred.
- REQ-015 SHALL have port irq, output, 1 bit: one-cycle pulse marking the first failure after reset or clear.
- REQ-016 SHALL have port first_idx, output, $clog2(N_SRC) bits: source index of the first failure.
- REQ-017 SHALL have port first_ts, output, TS_W bits: timestamp of the first failure.
- REQ-018 SHALL have port total_cnt, output, TOT_W bits: saturating count of all failures.

Function
- REQ-019 SHALL implement FSM states IDLE (no failure latched), LATCHED and CLEARING.
- REQ-020 In IDLE, any set fail_vec bit SHALL move the FSM to LATCHED.
- REQ-021 On the IDLE-to-LATCHED move, first_idx SHALL capture the lowest set bit index, first_ts SHALL capture the current timestamp, and irq SHALL pulse high in the next cycle.
- REQ-022 In LATCHED, first_idx and first_ts SHALL hold, and further failures SHALL only update the counters.
- REQ-023 clr_req in IDLE or LATCHED SHALL move the FSM to CLEARING.
- REQ-024 In CLEARING, all counters, any_fail, first_idx and first_ts SHALL be zeroed and clr_ack SHALL be high for exactly that cycle; the FSM SHALL then return to IDLE.
- REQ-025 fail_vec bits present in the clr_req cycle or in the CLEARING cycle SHALL be discarded (clear wins).
- REQ-026 Each per-source counter SHALL increment by 1 per set bit per cycle and saturate at 2^CNT_W-1.
- REQ-027 total_cnt SHALL add the popcount of fail_vec per cycle and saturate at 2^TOT_W-1, with no wrap.
- REQ-028 any_fail SHALL equal (state==LATCHED).
- REQ-029 rd_req SHALL produce rd_ack exactly one cycle later, with rd_cnt holding the registered counter value sampled in the rd_req cycle.
- REQ-030 rd_cnt SHALL be 0 when rd_idx>=N_SRC, and SHALL be 0 whenever rd_ack is low.
- REQ-031 A simultaneous increment and read of the same source SHALL return the pre-increment value.
- REQ-032 A read during CLEARING SHALL return 0.

Reset
- REQ-033 Assertion of rst SHALL immediately force the FSM to IDLE and all outputs and counters to 0, including the timestamp, irq, clr_ack and rd_ack.
- REQ-034 Deassertion of rst SHALL be recognised on the next clk edge, and a failure in that cycle SHALL be captured normally.
- REQ-035 A reset mid-read or mid-clear SHALL abort the operation with no ack issued.

Configuration
- REQ-036 With macro ASSERT_FAIL_TIMESTAMP_EN defined, a free-running TS_W-bit cycle counter SHALL exist, starting at 0 after reset or clear, incrementing each cycle and wrapping at 2^TS_W.
- REQ-037 With ASSERT_FAIL_TIMESTAMP_EN defined, first_ts SHALL capture the counter value in the cycle the failure is sampled.
- REQ-038 Without ASSERT_FAIL_TIMESTAMP_EN, no timestamp counter SHALL be built and first_ts SHALL be tied to 0.

Verification
- REQ-039 Reset, then fail_vec=8'h00 for 5 cycles, then 8'h14 -> first_idx=2, irq pulses once, total_cnt=2, counters 2 and 4 each =1, first_ts=5 (macro on) or 0 (macro off).
- REQ-040 fail_vec bit 0 held for 300 cycles with CNT_W=8 -> rd_idx=0 gives rd_cnt=255 and total_cnt=300.
- REQ-041 clr_req raised together with fail_vec=8'h01 -> clr_ack after one cycle, all counters 0, any_fail=0, and no irq.
- REQ-042 Read rd_idx=3 while bit 3 fails in the same cycle, with the counter at 4 -> rd_ack next cycle with rd_cnt=4, and a later read returns 5.
- REQ-043 rst asserted asynchronously mid-LATCHED with total_cnt=7 -> all outputs 0 before the next clk edge.
- REQ-044 Timestamp wrap with TS_W=4 and macro on: first failure at cycle 18 after reset -> first_ts=2.
